// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply / restoring divide sequencer for mul/div R-type ops.
// Stalls decode while iterating, then emits a single writeback beat with exception status.
module muldiv_sequencer #(
  parameter int WIDTH        = 32,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_rd,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             exception,
  output logic [WIDTH-1:0] exc_code
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opb_q, opb_d;       // multiplicand or divisor magnitude
  logic                 sign_q, sign_d;
  logic [4:0]           rd_q, rd_d;
  logic                 exc_q, exc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [4:0]           result_rd_q, result_rd_d;
  logic [WIDTH-1:0]     exc_code_q, exc_code_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, prod_s;
  logic                 mul_ovf;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_s;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_s    = sign_q ? -mul_next : mul_next;
    // Signed product fits WIDTH bits only if the top WIDTH+1 bits are a pure sign extension.
    mul_ovf   = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
    quo_s     = sign_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    sign_d      = sign_q;
    rd_d        = rd_q;
    exc_d       = exc_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    exc_code_d  = exc_code_q;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = start_mul | start_div;
        if (start_mul || start_div) begin
          rd_d   = dest_rd;
          sign_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          cnt_d  = '0;
          if (start_mul) begin
            state_d = S_MUL;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            opb_d   = mag_a;
          end else if (operand_b == '0) begin
            state_d     = S_DONE;
            result_d    = '0;
            result_rd_d = dest_rd;
            exc_d       = 1'b1;
            exc_code_d  = WIDTH'(DIV_EXC_CODE);
          end else begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opb_d   = mag_b;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          result_d    = prod_s[WIDTH-1:0];
          result_rd_d = rd_q;
          exc_d       = mul_ovf;
          exc_code_d  = mul_ovf ? WIDTH'(MUL_EXC_CODE) : '0;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          result_d    = quo_s;
          result_rd_d = rd_q;
          exc_d       = 1'b0;
          exc_code_d  = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cancel) begin
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      sign_q      <= 1'b0;
      rd_q        <= '0;
      exc_q       <= 1'b0;
      result_q    <= '0;
      result_rd_q <= '0;
      exc_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      sign_q      <= sign_d;
      rd_q        <= rd_d;
      exc_q       <= exc_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
      exc_code_q  <= exc_code_d;
    end
  end

  // A cancel arriving in the DONE cycle suppresses the writeback beat.
  assign result_valid = (state_q == S_DONE) && !cancel;
  assign exception    = result_valid && exc_q;
  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign exc_code     = exc_code_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected writebacks are queued at issue
// and compared when the DUT raises result_valid.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_mul = 1'b0;
  logic          start_div = 1'b0;
  logic          cancel = 1'b0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic [4:0]    dest_rd = '0;
  logic          stall;
  logic          result_valid;
  logic [W-1:0]  result;
  logic [4:0]    result_rd;
  logic          exception;
  logic [W-1:0]  exc_code;

  muldiv_sequencer #(.WIDTH(W), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_mul    (start_mul),
    .start_div    (start_div),
    .cancel       (cancel),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .dest_rd      (dest_rd),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .result_rd    (result_rd),
    .exception    (exception),
    .exc_code     (exc_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] code;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv, q;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    e.rd = rd;
    if (is_mul) begin
      p     = sa * sbv;
      e.res = p[31:0];
      e.exc = !((p[63:31] == 33'h0) || (p[63:31] == {33{1'b1}}));
      e.code = e.exc ? 32'd4 : 32'd0;
    end else if (b == 32'd0) begin
      e.res  = 32'd0;
      e.exc  = 1'b1;
      e.code = 32'd5;
    end else begin
      q      = sa / sbv;
      p      = q;
      e.res  = p[31:0];
      e.exc  = 1'b0;
      e.code = 32'd0;
    end
    return e;
  endfunction

  task automatic compare_beat(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_rd"}, result_rd, e.rd);
      check({tag, "_exception"}, exception, e.exc);
      check({tag, "_exc_code"}, exc_code, e.code);
    end
  endtask

  // Issue one op, count stall cycles up to the writeback beat, then score it.
  task automatic run_op(input string tag, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int stall_cnt;
    int exp_stall;
    bit seen;
    @(negedge clock);
    start_mul = m; start_div = d; operand_a = a; operand_b = b; dest_rd = rd;
    sb.push_back(model(m, a, b, rd));
    exp_stall = (!m && b == 32'd0) ? 1 : 33;
    #1 check({tag, "_stall_accept"}, stall, 1);
    @(posedge clock); #1;
    start_mul = 0; start_div = 0;
    operand_a = $urandom; operand_b = $urandom; dest_rd = 5'($urandom);
    stall_cnt = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (result_valid) seen = 1;
      else if (stall) stall_cnt++;
    end
    check({tag, "_valid_seen"}, seen, 1);
    check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    check({tag, "_stall_done"}, stall, 0);
    compare_beat(tag);
    @(negedge clock);
    check({tag, "_valid_one_cycle"}, result_valid, 0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit quiet;
    quiet = 1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (result_valid) quiet = 0;
    end
    check(tag, quiet, 1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_stall", stall, 0);
    check("rst_valid", result_valid, 0);
    check("rst_exception", exception, 0);
    check("rst_result", result, 0);
    check("rst_rd", result_rd, 0);
    check("rst_exc_code", exc_code, 0);
    @(negedge clock); reset = 1'b1;

    // Main function
    run_op("mul_7x-6", 1, 0, 32'd7, -32'sd6, 5'd3);
    run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd4);
    run_op("div_-7/2", 0, 1, -32'sd7, 32'd2, 5'd9);
    run_op("div_by_0", 0, 1, 32'd100, 32'd0, 5'd11);
    run_op("mul_neg_neg", 1, 0, -32'sd3, -32'sd5, 5'd1);
    run_op("mul_max_x2", 1, 0, 32'h7FFF_FFFF, 32'd2, 5'd2);
    run_op("mul_edge_fit", 1, 0, -32'sd65536, 32'd32768, 5'd5);
    run_op("mul_edge_pos", 1, 0, 32'h0000_FFFF, 32'h0000_8000, 5'd6);
    run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    run_op("div_-100/7", 0, 1, -32'sd100, 32'd7, 5'd8);
    run_op("div_big", 0, 1, 32'h7FFF_FFFF, 32'h0000_0003, 5'd31);

    // Cancel mid-divide
    @(negedge clock);
    start_div = 1; operand_a = 32'd1000; operand_b = 32'd3; dest_rd = 5'd12;
    @(posedge clock); #1 start_div = 0;
    repeat (9) @(negedge clock);
    cancel = 1;
    @(posedge clock); #1 cancel = 0;
    @(negedge clock);
    check("cancel_stall_drop", stall, 0);
    expect_quiet("cancel_no_valid", 40);
    run_op("mul_3x4_after_cancel", 1, 0, 32'd3, 32'd4, 5'd13);

    // Cancel together with start in IDLE: not accepted
    @(negedge clock);
    start_mul = 1; cancel = 1; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clock); #1 start_mul = 0; cancel = 0;
    @(negedge clock);
    check("cancel_start_not_accepted", stall, 0);
    expect_quiet("cancel_start_no_valid", 40);

    // Cancel during the DONE cycle suppresses the beat
    @(negedge clock);
    start_div = 1; operand_a = 32'd50; operand_b = 32'd0;
    @(posedge clock); #1 start_div = 0; cancel = 1;
    @(negedge clock);
    check("cancel_in_done_valid", result_valid, 0);
    @(posedge clock); #1 cancel = 0;
    expect_quiet("cancel_in_done_quiet", 5);

    // Start held through DONE is ignored there
    @(negedge clock);
    start_div = 1; operand_a = 32'd77; operand_b = 32'd0; dest_rd = 5'd14;
    sb.push_back(model(0, 32'd77, 32'd0, 5'd14));
    @(negedge clock);
    check("start_in_done_valid", result_valid, 1);
    compare_beat("start_in_done");
    @(negedge clock);
    check("start_in_done_ignored", result_valid, 0);
    check("start_in_done_idle_stall", stall, 1);
    start_div = 0;
    expect_quiet("start_in_done_quiet", 5);

    // Both starts: multiply wins
    run_op("both_starts_5x5", 1, 1, 32'd5, 32'd5, 5'd15);

    // Asynchronous reset mid-run
    @(negedge clock);
    start_mul = 1; operand_a = 32'd9; operand_b = 32'd9; dest_rd = 5'd16;
    @(posedge clock); #1 start_mul = 0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_exception", exception, 0);
    check("midrst_result", result, 0);
    check("midrst_rd", result_rd, 0);
    check("midrst_exc_code", exc_code, 0);
    @(negedge clock); reset = 1'b1;
    expect_quiet("midrst_no_partial", 40);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
